vga_mode_ctrl: RTL and testbench

Frame-synchronous controller that owns the 4-bit layer-select word driving the VGA pixel mux. It debounces two board buttons that step the base video mode and the overlay mode, holds requested changes in a shadow register, and commits them only at frame boundaries so no frame ever shows mixed layers. An optional hit-flash feature forces the test-colour overlay for a fixed number of frames after a game hit event.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/button_debounce.sv | 46 ++++
 rtl/vga_mode_ctrl.sv | 143 ++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA layer-select path: video/overlay encodings,
// the packed layer-select word, controller FSM state and field step helpers.
// No ports; pure compile-time definitions.
package vga_pkg;

    typedef enum logic [1:0] {
        CAM_GAME = 2'b00,
        CHANNEL  = 2'b01,
        THRESH   = 2'b10,
        Y_MASK   = 2'b11
    } video_mode_t;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        CROSSHAIR = 2'b01,
        SPRITE    = 2'b10,
        TEST      = 2'b11
    } overlay_t;

    // Overlay in the upper half, base mode in the lower half.
    typedef struct packed {
        overlay_t    ov;
        video_mode_t base;
    } layer_sel_t;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_PENDING = 2'b01,
        ST_FLASH   = 2'b10
    } ctrl_state_t;

    function automatic video_mode_t next_base(input video_mode_t b);
        return video_mode_t'(2'(b + 2'd1));
    endfunction

    // TEST is only ever entered by the flash path, so a button press skips it.
    function automatic overlay_t next_ov(input overlay_t o);
        case (o)
            NONE:      return CROSSHAIR;
            CROSSHAIR: return SPRITE;
            default:   return NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchronizer, saturating debouncer, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles, pulse registered.
// No backpressure; press_out is a one-cycle pulse per accepted press.
// Ports: clk_pixel_in/rst_n_in (async active-low), btn_in raw, press_out pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 650_000
) (
    input  logic clk_pixel_in,
    input  logic rst_n_in,
    input  logic btn_in,
    output logic press_out
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_ff1;
    logic          sync_ff2;
    logic          db_level;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_ff1  <= 1'b0;
            sync_ff2  <= 1'b0;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            press_out <= 1'b0;
        end else begin
            sync_ff1  <= btn_in;
            sync_ff2  <= sync_ff1;
            press_out <= 1'b0;
            if (sync_ff2 == db_level) begin
                // Input fell back to the accepted level: the candidate is dropped.
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Held long enough; accept and emit a pulse on the rising level only.
                db_level  <= sync_ff2;
                db_cnt    <= '0;
                press_out <= sync_ff2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Frame-synchronous owner of the VGA layer-select word; button steps land in a
// shadow and commit on new_frame_in. Latency: request->shadow 1 cycle, commit at frame edge.
// No backpressure; requests always accepted, sel_out changes at most once per frame.
// Ports: clk_pixel_in, rst_n_in (async active-low), mode_btn_in, overlay_btn_in,
// new_frame_in, hit_in -> sel_out[3:0], sel_update_out, pending_out.
// Optional hit-flash overlay enabled by defining VGA_MODE_CTRL_FLASH_EN.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 650_000,
    parameter int         FLASH_FRAMES    = 8,
    parameter logic [3:0] RESET_SEL       = 4'b0100
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       mode_btn_in,
    input  logic       overlay_btn_in,
    input  logic       new_frame_in,
    input  logic       hit_in,
    output logic [3:0] sel_out,
    output logic       sel_update_out,
    output logic       pending_out
);

    logic        mode_req;
    logic        ov_req;
    layer_sel_t  shadow;
    layer_sel_t  shadow_nxt;
    layer_sel_t  sel_q;
    layer_sel_t  sel_nxt;
    ctrl_state_t state;
    ctrl_state_t state_nxt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk_pixel_in (clk_pixel_in),
        .rst_n_in     (rst_n_in),
        .btn_in       (mode_btn_in),
        .press_out    (mode_req)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ov_db (
        .clk_pixel_in (clk_pixel_in),
        .rst_n_in     (rst_n_in),
        .btn_in       (overlay_btn_in),
        .press_out    (ov_req)
    );

    always_comb begin
        shadow_nxt = shadow;
        if (mode_req) shadow_nxt.base = next_base(shadow.base);
        if (ov_req)   shadow_nxt.ov   = next_ov(shadow.ov);
    end

`ifdef VGA_MODE_CTRL_FLASH_EN
    localparam int FCW = $clog2(FLASH_FRAMES + 1);

    logic           flash_latch;
    logic           latch_nxt;
    logic [FCW-1:0] flash_cnt;
    logic [FCW-1:0] cnt_nxt;

    always_comb begin
        sel_nxt   = sel_q;
        latch_nxt = flash_latch | hit_in;
        cnt_nxt   = flash_cnt;
        if (new_frame_in) begin
            case (state)
                ST_PENDING: begin
                    // Commit uses the pre-request shadow; a same-cycle request stays pending.
                    sel_nxt = shadow;
                    if (flash_latch) begin
                        sel_nxt.ov = TEST;
                        cnt_nxt    = FCW'(FLASH_FRAMES);
                        latch_nxt  = hit_in;
                    end
                end
                ST_FLASH: begin
                    sel_nxt.ov   = TEST;
                    sel_nxt.base = shadow.base;
                    if (flash_latch) begin
                        // A hit during the flash restarts the full duration.
                        cnt_nxt   = FCW'(FLASH_FRAMES);
                        latch_nxt = hit_in;
                    end else if (flash_cnt == FCW'(1)) begin
                        sel_nxt = shadow;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = flash_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A non-zero count means the overlay is still forced.
        if (cnt_nxt != '0)
            state_nxt = ST_FLASH;
        else if ((shadow_nxt != sel_nxt) || latch_nxt)
            state_nxt = ST_PENDING;
        else
            state_nxt = ST_NORMAL;
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flash_latch <= 1'b0;
            flash_cnt   <= '0;
        end else begin
            flash_latch <= latch_nxt;
            flash_cnt   <= cnt_nxt;
        end
    end
`else
    // hit_in stays on the port list so both builds share one pinout.
    logic unused_flash;
    assign unused_flash = hit_in | (FLASH_FRAMES == 0);

    always_comb begin
        sel_nxt = sel_q;
        if (new_frame_in && (state == ST_PENDING))
            sel_nxt = shadow;
        state_nxt = (shadow_nxt != sel_nxt) ? ST_PENDING : ST_NORMAL;
    end
`endif

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow         <= layer_sel_t'(RESET_SEL);
            sel_q          <= layer_sel_t'(RESET_SEL);
            state          <= ST_NORMAL;
            sel_update_out <= 1'b0;
            pending_out    <= 1'b0;
        end else begin
            shadow         <= shadow_nxt;
            sel_q          <= sel_nxt;
            state          <= state_nxt;
            sel_update_out <= (sel_nxt != sel_q);
            pending_out    <= (state_nxt == ST_PENDING);
        end
    end

    assign sel_out = sel_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with short debounce and a two-frame flash.
// Inputs are driven and outputs sampled on the falling clock edge.
// Prints a single summary line; individual mismatches print a FAIL line.
module tb_vga_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_btn;
    logic       ov_btn;
    logic       new_frame;
    logic       hit;
    logic [3:0] sel;
    logic       upd;
    logic       pend;

    int checks  = 0;
    int errors  = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    vga_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .FLASH_FRAMES    (2),
        .RESET_SEL       (4'b0100)
    ) dut (
        .clk_pixel_in   (clk),
        .rst_n_in       (rst_n),
        .mode_btn_in    (mode_btn),
        .overlay_btn_in (ov_btn),
        .new_frame_in   (new_frame),
        .hit_in         (hit),
        .sel_out        (sel),
        .sel_update_out (upd),
        .pending_out    (pend)
    );

    // Count update pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (upd) upd_cnt = upd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic frame_gap();
        tick(97);
        frame();
    endtask

    task automatic press(input bit ov);
        if (ov) ov_btn = 1'b1; else mode_btn = 1'b1;
        tick(12);
        ov_btn   = 1'b0;
        mode_btn = 1'b0;
        tick(12);
    endtask

    task automatic pulse_hit();
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic test_reset();
        int b;
        rst_n = 1'b0; mode_btn = 1'b0; ov_btn = 1'b0; new_frame = 1'b0; hit = 1'b0;
        tick(3);
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL rst_sel got=%b exp=0100", sel); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rst_upd got=%b exp=0", upd); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rst_pend got=%b exp=0", pend); end
        rst_n = 1'b1;
        tick(2);
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL rel_sel got=%b exp=0100", sel); end
        b = upd_cnt;
        repeat (3) frame_gap();
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL idle_sel got=%b exp=0100", sel); end
        checks++; if (upd_cnt !== b) begin errors++; $display("FAIL idle_upd got=%0d exp=%0d", upd_cnt, b); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL idle_pend got=%b exp=0", pend); end
    endtask

    task automatic test_mode_step();
        logic [3:0] exp_m [4];
        logic [3:0] prev;
        int b;
        exp_m = '{4'b0101, 4'b0110, 4'b0111, 4'b0100};
        prev  = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            b = upd_cnt;
            press(1'b0);
            checks++; if (pend !== 1'b1) begin errors++; $display("FAIL mode_pend[%0d] got=%b exp=1", i, pend); end
            checks++; if (sel !== prev) begin errors++; $display("FAIL mode_hold[%0d] got=%b exp=%b", i, sel, prev); end
            tick(60);
            frame();
            checks++; if (sel !== exp_m[i]) begin errors++; $display("FAIL mode_sel[%0d] got=%b exp=%b", i, sel, exp_m[i]); end
            checks++; if (upd_cnt !== b + 1) begin errors++; $display("FAIL mode_upd[%0d] got=%0d exp=%0d", i, upd_cnt - b, 1); end
            checks++; if (pend !== 1'b0) begin errors++; $display("FAIL mode_clr[%0d] got=%b exp=0", i, pend); end
            prev = exp_m[i];
        end
    endtask

    task automatic test_glitch_cycle();
        logic [3:0] exp_o [3];
        int b;
        exp_o = '{4'b1000, 4'b0000, 4'b0100};
        b = upd_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ov_btn = 1'b1;
            tick(2);
            ov_btn = 1'b0;
            tick(10);
        end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL glitch_pend got=%b exp=0", pend); end
        frame_gap();
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL glitch_sel got=%b exp=0100", sel); end
        checks++; if (upd_cnt !== b) begin errors++; $display("FAIL glitch_upd got=%0d exp=%0d", upd_cnt, b); end
        for (int i = 0; i < 3; i++) begin
            b = upd_cnt;
            press(1'b1);
            tick(60);
            frame();
            checks++; if (sel !== exp_o[i]) begin errors++; $display("FAIL ov_sel[%0d] got=%b exp=%b", i, sel, exp_o[i]); end
            checks++; if (upd_cnt !== b + 1) begin errors++; $display("FAIL ov_upd[%0d] got=%0d exp=1", i, upd_cnt - b); end
        end
    endtask

    task automatic test_race();
        int b;
        b = upd_cnt;
        // Button high before edge 0 yields a request in the cycle before edge 6,
        // so the frame pulse sampled at edge 6 coincides with the shadow update.
        @(negedge clk);
        mode_btn = 1'b1;
        tick(6);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL race_sel got=%b exp=0100", sel); end
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL race_pend got=%b exp=1", pend); end
        checks++; if (upd_cnt !== b) begin errors++; $display("FAIL race_upd got=%0d exp=%0d", upd_cnt, b); end
        tick(12);
        mode_btn = 1'b0;
        tick(60);
        frame();
        checks++; if (sel !== 4'b0101) begin errors++; $display("FAIL race_next got=%b exp=0101", sel); end
        checks++; if (upd_cnt !== b + 1) begin errors++; $display("FAIL race_upd2 got=%0d exp=1", upd_cnt - b); end
    endtask

    task automatic test_flash();
        int b;
        b = upd_cnt;
        tick(20);
        pulse_hit();
`ifdef VGA_MODE_CTRL_FLASH_EN
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL hit_pend got=%b exp=1", pend); end
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL flash_f1 got=%b exp=1101", sel); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL flash_pend got=%b exp=0", pend); end
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL flash_f2 got=%b exp=1101", sel); end
        frame_gap();
        checks++; if (sel !== 4'b0101) begin errors++; $display("FAIL flash_f3 got=%b exp=0101", sel); end
        checks++; if (upd_cnt !== b + 2) begin errors++; $display("FAIL flash_upd got=%0d exp=2", upd_cnt - b); end
        // Second hit lands in the last flash frame and restarts the count.
        pulse_hit();
        frame_gap();
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL ext_f2 got=%b exp=1101", sel); end
        pulse_hit();
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL ext_f3 got=%b exp=1101", sel); end
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL ext_f4 got=%b exp=1101", sel); end
        frame_gap();
        checks++; if (sel !== 4'b0101) begin errors++; $display("FAIL ext_f5 got=%b exp=0101", sel); end
`else
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL hit_pend got=%b exp=0", pend); end
        frame_gap();
        checks++; if (sel !== 4'b0101) begin errors++; $display("FAIL hit_sel got=%b exp=0101", sel); end
        checks++; if (upd_cnt !== b) begin errors++; $display("FAIL hit_upd got=%0d exp=%0d", upd_cnt, b); end
`endif
    endtask

    task automatic test_reset_mid();
        int b;
`ifdef VGA_MODE_CTRL_FLASH_EN
        pulse_hit();
        frame_gap();
        checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL mid_flash got=%b exp=1101", sel); end
`endif
        press(1'b0);
        tick(10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL mid_rst_sel got=%b exp=0100", sel); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL mid_rst_pend got=%b exp=0", pend); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL mid_rst_upd got=%b exp=0", upd); end
        tick(3);
        rst_n = 1'b1;
        b = upd_cnt;
        repeat (3) frame_gap();
        checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL post_rst_sel got=%b exp=0100", sel); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL post_rst_pend got=%b exp=0", pend); end
        checks++; if (upd_cnt !== b) begin errors++; $display("FAIL post_rst_upd got=%0d exp=%0d", upd_cnt, b); end
    endtask

    initial begin
        test_reset();
        test_mode_step();
        test_glitch_cycle();
        test_race();
        test_flash();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
